key_conditioner: RTL and testbench

- Multi-channel input conditioner for the board's push-buttons and switches. It replaces the bare two-flop synchroniser on each input.
- Each channel passes through a parametrised synchroniser chain, then a debounce filter, then edge detection, then an optional hold-to-repeat generator.
- Outputs feed game-control logic (frog movement), which consumes single-cycle pulses.

---
 rtl/key_conditioner_if.sv | 15 +
 rtl/key_conditioner.sv | 155 +++++++++++++++
 tb/tb_key_conditioner.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw key inputs towards the conditioner and
// the conditioned level/pulse outputs back to the game-control logic.
interface key_conditioner_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] d;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] rel;
    logic [NUM_CH-1:0] rpt;
    logic [NUM_CH-1:0] hit;

    modport master (output d, input level, press, rel, rpt, hit);
    modport slave  (input d, output level, press, rel, rpt, hit);
endinterface

// File: rtl/key_conditioner.sv
// Multi-channel key conditioner: synchroniser chain, debounce filter, edge
// pulses and an optional hold-to-repeat generator for every input channel.
module key_conditioner #(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW_IN   = 1,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic             clk,
    input  logic             reset,
    key_conditioner_if.slave kc
);
    localparam logic INACTIVE = (ACTIVE_LOW_IN != 0) ? 1'b1 : 1'b0;
    localparam int   CW       = ($clog2(DEBOUNCE_CYCLES + 1) > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int   HMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   HW       = ($clog2(HMAX) > 1) ? $clog2(HMAX) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] RD_LAST = HW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [HW-1:0] RP_LAST = HW'(REPEAT_PERIOD - 1);
    localparam logic RPT_EN   = (REPEAT_DELAY > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    logic [NUM_CH-1:0] level_s;
    logic [NUM_CH-1:0] press_s;
    logic [NUM_CH-1:0] rel_s;
    logic [NUM_CH-1:0] rpt_s;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic [CW-1:0]          cnt_r;
        logic [CW-1:0]          cnt_nxt_s;
        logic [HW-1:0]          hcnt_r;
        logic [HW-1:0]          hcnt_nxt_s;
        rpt_state_t             state_r;
        rpt_state_t             state_nxt_s;
        logic                   level_r;
        logic                   press_r;
        logic                   rel_r;
        logic                   rpt_r;
        logic                   norm_s;
        logic                   accept_s;
        logic                   rise_s;
        logic                   fall_s;
        logic                   rpt_nxt_s;

        // Debounce: a new level is accepted only after an unbroken run of disagreeing samples
        always_comb begin
            norm_s    = sync_r[SYNC_STAGES-1] ^ INACTIVE;
            accept_s  = 1'b0;
            cnt_nxt_s = cnt_r;
            if (norm_s == level_r) begin
                cnt_nxt_s = {CW{1'b0}};
            end else if (cnt_r == DB_LAST) begin
                accept_s  = 1'b1;
                cnt_nxt_s = {CW{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + CW'(1);
            end
            rise_s = accept_s & norm_s;
            fall_s = accept_s & ~norm_s;
        end

        // Synchroniser, debounce counter, level and edge pulse registers
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_r  <= {SYNC_STAGES{INACTIVE}};
                cnt_r   <= {CW{1'b0}};
                level_r <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else begin
                sync_r  <= {sync_r[SYNC_STAGES-2:0], kc.d[c]};
                cnt_r   <= cnt_nxt_s;
                level_r <= accept_s ? norm_s : level_r;
                press_r <= rise_s;
                rel_r   <= fall_s;
            end
        end

        // Hold-to-repeat next state; a falling level always wins over a due repeat
        always_comb begin
            state_nxt_s = state_r;
            hcnt_nxt_s  = hcnt_r;
            rpt_nxt_s   = 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s && RPT_EN) begin
                        state_nxt_s = DELAY;
                        hcnt_nxt_s  = {HW{1'b0}};
                    end else begin
                        hcnt_nxt_s  = {HW{1'b0}};
                    end
                end
                DELAY: begin
                    if (fall_s) begin
                        state_nxt_s = IDLE;
                        hcnt_nxt_s  = {HW{1'b0}};
                    end else if (hcnt_r == RD_LAST) begin
                        state_nxt_s = REPEAT;
                        hcnt_nxt_s  = {HW{1'b0}};
                        rpt_nxt_s   = 1'b1;
                    end else begin
                        hcnt_nxt_s  = hcnt_r + HW'(1);
                    end
                end
                REPEAT: begin
                    if (fall_s) begin
                        state_nxt_s = IDLE;
                        hcnt_nxt_s  = {HW{1'b0}};
                    end else if (hcnt_r == RP_LAST) begin
                        hcnt_nxt_s  = {HW{1'b0}};
                        rpt_nxt_s   = 1'b1;
                    end else begin
                        hcnt_nxt_s  = hcnt_r + HW'(1);
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    hcnt_nxt_s  = {HW{1'b0}};
                end
            endcase
        end

        // Hold-to-repeat state register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_r <= IDLE;
                hcnt_r  <= {HW{1'b0}};
                rpt_r   <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                hcnt_r  <= hcnt_nxt_s;
                rpt_r   <= rpt_nxt_s;
            end
        end

        assign level_s[c] = level_r;
        assign press_s[c] = press_r;
        assign rel_s[c]   = rel_r;
        assign rpt_s[c]   = rpt_r;
    end

    assign kc.level = level_s;
    assign kc.press = press_s;
    assign kc.rel   = rel_s;
    assign kc.rpt   = rpt_s;
    assign kc.hit   = press_s | rpt_s;
endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key
// activity, compared every cycle against a behavioural reference model.
module tb_key_conditioner;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    key_conditioner_if #(.NUM_CH(N)) kif ();

    key_conditioner #(
        .NUM_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW_IN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .kc(kif)
    );

    always #5 clk = ~clk;

    // Reference model: raw history delayed S edges, disagreement run length,
    // and time held since the accepted press.
    logic [N-1:0] hist[$];
    int           run[N];
    int           age[N];
    logic [N-1:0] holding;
    logic [N-1:0] e_level, e_press, e_rel, e_rpt;

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < S; k++) hist.push_back({N{1'b1}});
        for (int c = 0; c < N; c++) begin
            run[c] = 0;
            age[c] = 0;
        end
        holding = '0; e_level = '0; e_press = '0; e_rel = '0; e_rpt = '0;
    endfunction

    function automatic void model_step(input logic [N-1:0] din);
        logic [N-1:0] seen;
        logic         pressed;
        hist.push_back(din);
        seen = hist.pop_front();
        for (int c = 0; c < N; c++) begin
            pressed = ~seen[c];
            e_press[c] = 1'b0; e_rel[c] = 1'b0; e_rpt[c] = 1'b0;
            if (pressed != e_level[c]) run[c]++; else run[c] = 0;
            if (run[c] == DB) begin
                run[c] = 0;
                e_level[c] = pressed;
                if (pressed) begin
                    e_press[c] = 1'b1; holding[c] = 1'b1; age[c] = 0;
                end else begin
                    e_rel[c] = 1'b1; holding[c] = 1'b0;
                end
            end else if (holding[c]) begin
                age[c]++;
                if (age[c] == RD || (age[c] > RD && (age[c] - RD) % RP == 0)) e_rpt[c] = 1'b1;
            end
        end
    endfunction

    function automatic logic [5*N-1:0] obs_vec();
        return {kif.level, kif.press, kif.rel, kif.rpt, kif.hit};
    endfunction

    function automatic logic [5*N-1:0] exp_vec();
        return {e_level, e_press, e_rel, e_rpt, e_press | e_rpt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) model_step(kif.d); else model_reset();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        kif.d = 4'h0;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== 20'h0) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: got %h expected 00000", i, obs_vec());
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_release edge %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 6) begin
                vectors++;
                if ({kif.level, kif.press} !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL reset_fresh_press: level/press got %h expected ff", {kif.level, kif.press});
                end
            end
        end
        kif.d = 4'hF;
        settle(12);
    endtask

    task automatic test_clean_press();
        settle($urandom_range(1, 5));
        kif.d[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL clean_press edge %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 6) begin
                vectors++;
                if ({kif.level[0], kif.press[0], kif.hit[0]} !== 3'b111) begin
                    miscompares++;
                    $display("FAIL clean_press_edge6: got %b expected 111", {kif.level[0], kif.press[0], kif.hit[0]});
                end
            end
            if (i == 7) begin
                vectors++;
                if ({kif.press[0], kif.hit[0]} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL clean_press_edge7: got %b expected 00", {kif.press[0], kif.hit[0]});
                end
            end
        end
        kif.d[0] = 1'b1;
        settle(10);
    endtask

    task automatic test_bounce();
        settle($urandom_range(1, 5));
        for (int t = 0; t < 20; t++) begin
            kif.d[1] = (t < 8) ? (((t / 2) % 2) != 0) : 1'b0;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL bounce t %0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
            if (t < 13) begin
                vectors++;
                if ({kif.level[1], kif.press[1], kif.rel[1]} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL bounce_quiet t %0d: got %b expected 000", t, {kif.level[1], kif.press[1], kif.rel[1]});
                end
            end
            if (t == 13) begin
                vectors++;
                if ({kif.level[1], kif.press[1]} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL bounce_accept: got %b expected 11", {kif.level[1], kif.press[1]});
                end
            end
        end
        kif.d[1] = 1'b1;
        settle(12);
    endtask

    task automatic test_auto_repeat();
        int p;
        int hits;
        int offs[$];
        p = -1;
        hits = 0;
        kif.d[2] = 1'b0;
        for (int t = 0; t < 36; t++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL auto_repeat t %0d: got %h expected %h", t, obs_vec(), exp_vec());
            end
            if (kif.press[2]) p = t;
            if (kif.hit[2]) hits++;
            if (kif.rpt[2] && p >= 0) offs.push_back(t - p);
        end
        vectors++;
        if (p !== 5) begin
            miscompares++;
            $display("FAIL repeat_press_time: got %0d expected 5", p);
        end
        vectors++;
        if (hits !== 7) begin
            miscompares++;
            $display("FAIL repeat_hit_count: got %0d expected 7", hits);
        end
        vectors++;
        if (offs.size() !== 6) begin
            miscompares++;
            $display("FAIL repeat_count: got %0d expected 6", offs.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (offs[k] !== 8 + 4 * k) begin
                    miscompares++;
                    $display("FAIL repeat_offset %0d: got %0d expected %0d", k, offs[k], 8 + 4 * k);
                end
            end
        end
    endtask

    task automatic test_release_priority();
        bit found;
        found = 1'b0;
        for (int j = 0; j < 10 && !found; j++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rel_prio_wait j %0d: got %h expected %h", j, obs_vec(), exp_vec());
            end
            if (kif.rpt[2]) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rel_prio_timeout: got no repeat expected a repeat within 10 cycles");
            kif.d[2] = 1'b1;
            settle(12);
            return;
        end
        for (int j = 1; j <= 16; j++) begin
            if (j == 3) kif.d[2] = 1'b1;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rel_prio j %0d: got %h expected %h", j, obs_vec(), exp_vec());
            end
            if (j == 4) begin
                vectors++;
                if (kif.rpt[2] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rel_prio_last_rpt: got %b expected 1", kif.rpt[2]);
                end
            end
            if (j == 8) begin
                vectors++;
                if ({kif.rel[2], kif.rpt[2], kif.level[2]} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL rel_prio_edge: rel/rpt/level got %b expected 100", {kif.rel[2], kif.rpt[2], kif.level[2]});
                end
            end
            if (j > 8) begin
                vectors++;
                if (kif.rpt[2] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rel_prio_after j %0d: rpt got %b expected 0", j, kif.rpt[2]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        settle(4);
        kif.d[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 16) kif.d[3] = 1'b0;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL mid_reset_pre i %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (obs_vec() !== 20'h0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got %h expected 00000", obs_vec());
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL mid_reset_hold i %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL mid_reset_post edge %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 5) begin
                vectors++;
                if (kif.level[3:2] !== 2'b00) begin
                    miscompares++;
                    $display("FAIL mid_reset_early: level got %b expected 00", kif.level[3:2]);
                end
            end
            if (i == 6) begin
                vectors++;
                if ({kif.press[3:2], kif.level[3:2]} !== 4'b1111) begin
                    miscompares++;
                    $display("FAIL mid_reset_repress: got %b expected 1111", {kif.press[3:2], kif.level[3:2]});
                end
            end
        end
        kif.d = 4'hF;
        settle(12);
    endtask

    task automatic test_random();
        int rate;
        for (int i = 0; i < 1500; i++) begin
            rate = (((i / 250) % 2) == 0) ? 4 : 20;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(99) < rate) kif.d[c] = ~kif.d[c];
            end
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random i %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        kif.d = 4'hF;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_priority();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
